lpm_nexthop: RTL

Next-hop resolution stage sitting directly downstream of the longest-prefix-match block. It consumes each matched prefix (`valid_out`/`output_prefix` of the LPM stage) and looks it up in a small software-programmed prefix→next-hop table. Each result is buffered in an output FIFO with a valid/ready handshake toward the forwarding logic. Hit, miss and drop statistics are kept.

---
 rtl/lpm_nexthop.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lpm_nexthop.sv
// lpm_nexthop: next-hop resolution behind the longest-prefix-match stage.
// Captures each matched prefix, looks it up exactly in a small programmable
// prefix->hop table (lowest valid index wins), and queues the result in an
// output FIFO with a valid/ready handshake. Hit/miss/drop counters saturate.
module lpm_nexthop #(
    parameter int ENTRIES     = 4,
    parameter int HOP_W       = 4,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_HOP = 0,
    localparam int IDX_W      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             match_valid,
    input  logic [31:0]      match_prefix,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [31:0]      cfg_prefix,
    input  logic [HOP_W-1:0] cfg_hop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prefix,
    output logic [HOP_W-1:0] out_hop,
    output logic             out_miss,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [HOP_W-1:0] MISS_HOP = HOP_W'(DEFAULT_HOP);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-hop table: valid bits are control, prefix/hop are plain data.
    logic [ENTRIES-1:0] tbl_en;
    logic [31:0]        tbl_prefix [ENTRIES];
    logic [HOP_W-1:0]   tbl_hop    [ENTRIES];

    // Stage 1 capture registers.
    logic               vld_p1;
    logic [31:0]        prefix_p1;

    // Stage 2 resolve result (combinational from stage-1 registers and table).
    logic               hit_p2;
    logic [HOP_W-1:0]   hop_p2;

    // Output FIFO storage and bookkeeping.
    logic [31:0]        fifo_prefix [DEPTH];
    logic [HOP_W-1:0]   fifo_hop    [DEPTH];
    logic [DEPTH-1:0]   fifo_miss;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic               pop;
    logic               push;
    logic               drop;

    // ---- table programming ----

    // Entry valid bits: cleared on reset so the table starts empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_en <= '0;
        end else if (cfg_we) begin
            tbl_en[cfg_idx] <= cfg_en;
        end
    end

    // Entry payload: only meaningful once its valid bit is set.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_prefix[cfg_idx] <= cfg_prefix;
            tbl_hop[cfg_idx]    <= cfg_hop;
        end
    end

    // ---- stage 1: capture ----

    // Stage-1 valid follows the upstream strobe every cycle (no backpressure).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= match_valid;
        end
    end

    // Stage-1 prefix only loads on a valid match.
    always_ff @(posedge clk) begin
        if (match_valid) begin
            prefix_p1 <= match_prefix;
        end
    end

    // ---- stage 2: resolve ----

    // Exact-match search; scanning downward lets the lowest index win.
    always_comb begin
        hit_p2 = 1'b0;
        hop_p2 = MISS_HOP;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_en[i] && (tbl_prefix[i] == prefix_p1)) begin
                hit_p2 = 1'b1;
                hop_p2 = tbl_hop[i];
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop  = (count != '0) && out_ready;
        push = vld_p1 && ((count != FULL_CNT) || pop);
        drop = vld_p1 && !push;
    end

    // FIFO payload write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_prefix[wr_ptr] <= prefix_p1;
            fifo_hop[wr_ptr]    <= hop_p2;
            fifo_miss[wr_ptr]   <= !hit_p2;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Statistics: every stage-2 result is a hit or a miss, even if dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (vld_p1 && hit_p2) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (vld_p1 && !hit_p2) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // ---- output: FIFO head ----

    // Head fields come from registers only; forced to zero while empty so
    // the reset state is clean regardless of stale storage contents.
    always_comb begin
        out_valid  = (count != '0);
        out_prefix = out_valid ? fifo_prefix[rd_ptr] : '0;
        out_hop    = out_valid ? fifo_hop[rd_ptr] : '0;
        out_miss   = out_valid ? fifo_miss[rd_ptr] : 1'b0;
    end

endmodule
